// File: rtl/reqack_tb_pkg.sv
// reqack_tb_pkg: shared state/error encodings, LFSR polynomial and per-channel seed derivation
package reqack_tb_pkg;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} src_state_e;
   typedef enum logic [1:0] {D_WAIT, D_DELAY, D_ACK} dst_state_e;
   typedef enum logic [1:0] {ERR_NONE, ERR_IMBALANCE, ERR_TIMEOUT, ERR_PROTOCOL} err_code_e;

   localparam logic [15:0] LfsrPoly = 16'hB400;
   localparam logic [15:0] SeedStep = 16'h9E37;

   // Spread channel seeds apart; an all-zero seed would lock the LFSR, so it is replaced by 1.
   function automatic logic [15:0] chan_seed(input logic [15:0] base, input int unsigned idx);
      logic [15:0] s;
      s = base ^ 16'(idx * SeedStep);
      return (s == 16'h0000) ? 16'h0001 : s;
   endfunction

endpackage

// File: rtl/reqack_tb_lfsr.sv
// reqack_tb_lfsr: 16-bit Galois LFSR, steps once per enabled cycle and exposes its low RndW bits
module reqack_tb_lfsr
   import reqack_tb_pkg::*;
#(
   parameter logic [15:0] Seed = 16'h0001,
   parameter int          RndW = 3
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            en_i,
   output logic [RndW-1:0] rnd_o
);

   logic [15:0] state_q;

   // shift right, folding the polynomial back in whenever a one drops out
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= Seed;
      else if (en_i) state_q <= state_q[0] ? ((state_q >> 1) ^ LfsrPoly) : (state_q >> 1);
   end

   assign rnd_o = state_q[RndW-1:0];

endmodule

// File: rtl/reqack_traffic_checker.sv
// reqack_traffic_checker: multi-channel REQ/ACK traffic generator and scoreboard; macro REQACK_TB_RANDOM_GAP_EN enables random inter-request gaps
module reqack_traffic_checker
   import reqack_tb_pkg::*;
#(
   parameter int          NumChannels     = 2,
   parameter int          NumTransactions = 8,
   parameter int          DelayWidth      = 3,
   parameter int          GapWidth        = 2,
   parameter int          TimeoutCycles   = 256,
   parameter logic [15:0] LfsrSeed        = 16'hACE1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   output logic [NumChannels-1:0] src_req_o,
   input  logic [NumChannels-1:0] src_ack_i,
   input  logic [NumChannels-1:0] dst_req_i,
   output logic [NumChannels-1:0] dst_ack_o,
   output logic                   test_done_o,
   output logic                   test_passed_o,
   output logic [1:0]             error_o
);

   localparam int              CntW   = $clog2(NumTransactions + 1);
   localparam logic [CntW-1:0] NumTr  = CntW'(NumTransactions);
   localparam logic [CntW-1:0] LastTr = CntW'(NumTransactions - 1);
   localparam logic [CntW:0]   One    = (CntW + 1)'(1);
   localparam int              WdW    = $clog2(TimeoutCycles + 1);
   localparam logic [WdW-1:0]  WdLast = WdW'(TimeoutCycles - 1);
`ifdef REQACK_TB_RANDOM_GAP_EN
   localparam int              RndW   = (DelayWidth > GapWidth) ? DelayWidth : GapWidth;
`else
   localparam int              RndW   = DelayWidth;
`endif

   logic [NumChannels-1:0] src_hs, dst_hs, ch_done, ch_imb, ch_prot;
   logic                   any_hs, timeout, done_q, passed_q;
   logic [WdW-1:0]         wd_q;
   err_code_e              err_q, err_d;

   for (genvar i = 0; i < NumChannels; i++) begin : g_ch
      src_state_e            src_q, src_d;
      dst_state_e            dst_q, dst_d;
      logic [CntW-1:0]       src_cnt_q, dst_cnt_q;
      logic [DelayWidth-1:0] dly_q, dly_d;
      logic [GapWidth-1:0]   gap_q, gap_d, gap_len;
      logic [RndW-1:0]       rnd;

      reqack_tb_lfsr #(
         .Seed(chan_seed(LfsrSeed, i)),
         .RndW(RndW)
      ) u_lfsr (
         .clk_i (clk_i),
         .rst_ni(rst_ni),
         .en_i  (dst_hs[i]),
         .rnd_o (rnd)
      );

`ifdef REQACK_TB_RANDOM_GAP_EN
      assign gap_len = rnd[GapWidth-1:0];
`else
      assign gap_len = '0;
`endif

      // outputs are silenced as soon as the run is over, whatever the FSMs hold
      assign src_req_o[i] = (src_q == S_REQ) && !done_q;
      assign dst_ack_o[i] = (dst_q == D_ACK) && !done_q;
      assign src_hs[i]    = src_req_o[i] && src_ack_i[i];
      assign dst_hs[i]    = dst_ack_o[i] && dst_req_i[i];
      assign ch_done[i]   = (src_cnt_q == NumTr) && (dst_cnt_q == NumTr);
      assign ch_imb[i]    = ({1'b0, src_cnt_q} > {1'b0, dst_cnt_q} + One) ||
                            ({1'b0, dst_cnt_q} > {1'b0, src_cnt_q} + One);
      assign ch_prot[i]   = (src_ack_i[i] && !src_req_o[i]) ||
                            ((dst_q == D_DELAY) && !dst_req_i[i]) ||
                            ((dst_q == D_WAIT) && dst_req_i[i] && (dst_cnt_q == NumTr));

      // per-channel state, saturating handshake counters and delay/gap timers
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            src_q     <= S_IDLE;
            dst_q     <= D_WAIT;
            src_cnt_q <= '0;
            dst_cnt_q <= '0;
            dly_q     <= '0;
            gap_q     <= '0;
         end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            dly_q <= dly_d;
            gap_q <= gap_d;
            if (src_hs[i] && (src_cnt_q != NumTr)) src_cnt_q <= src_cnt_q + CntW'(1);
            if (dst_hs[i] && (dst_cnt_q != NumTr)) dst_cnt_q <= dst_cnt_q + CntW'(1);
         end
      end

      // source FSM: request after reset, re-arm after each handshake until the quota is met
      always_comb begin
         src_d = src_q;
         gap_d = gap_q;
         if (!done_q) begin
            case (src_q)
               S_IDLE: src_d = (src_cnt_q != NumTr) ? S_REQ : S_IDLE;
               S_REQ: begin
                  if (src_hs[i]) begin
                     src_d = (src_cnt_q == LastTr) ? S_IDLE : ((gap_len != '0) ? S_GAP : S_REQ);
                     gap_d = gap_len;
                  end
               end
               S_GAP: begin
                  gap_d = gap_q - GapWidth'(1);
                  src_d = (gap_q == GapWidth'(1)) ? S_REQ : S_GAP;
               end
               default: src_d = S_IDLE;
            endcase
         end
      end

      // destination FSM: random wait after a request, then a single-cycle ack
      always_comb begin
         dst_d = dst_q;
         dly_d = dly_q;
         if (!done_q) begin
            case (dst_q)
               D_WAIT: begin
                  if (dst_req_i[i]) begin
                     dly_d = rnd[DelayWidth-1:0];
                     dst_d = (rnd[DelayWidth-1:0] == '0) ? D_ACK : D_DELAY;
                  end
               end
               D_DELAY: begin
                  dly_d = dly_q - DelayWidth'(1);
                  dst_d = (dly_q == DelayWidth'(1)) ? D_ACK : D_DELAY;
               end
               D_ACK:   dst_d = D_WAIT;
               default: dst_d = D_WAIT;
            endcase
         end
      end
   end

   assign any_hs  = |{src_hs, dst_hs};
   assign timeout = (wd_q == WdLast) && !any_hs;
   assign err_d   = (|ch_imb)  ? ERR_IMBALANCE :
                    timeout    ? ERR_TIMEOUT   :
                    (|ch_prot) ? ERR_PROTOCOL  : ERR_NONE;

   // watchdog: counts quiet cycles, restarted by any handshake anywhere
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) wd_q <= '0;
      else if (any_hs) wd_q <= '0;
      else if (wd_q != WdLast) wd_q <= wd_q + WdW'(1);
   end

   // verdict: the first error is latched and beats a simultaneous success
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         done_q   <= 1'b0;
         passed_q <= 1'b0;
         err_q    <= ERR_NONE;
      end else if (!done_q) begin
         if (err_d != ERR_NONE) begin
            done_q <= 1'b1;
            err_q  <= err_d;
         end else if (&ch_done) begin
            done_q   <= 1'b1;
            passed_q <= 1'b1;
         end
      end
   end

   assign test_done_o   = done_q;
   assign test_passed_o = passed_q;
   assign error_o       = err_q;

endmodule
